multiplier_8x8: RTL and testbench
=================================

MULTIPLIER_8X8 -- requirements
Module: multiplier_8x8

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, and the clock and reset ports SHALL be named as the codebase does: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 F  input  1  load strobe; 1 = H and D carry a valid element this cycle.
REQ-005 H  input  16  signed two's-complement element of left matrix H, row-major.
REQ-006 D  input  16  signed two's-complement element of right matrix D, row-major.
REQ-007 Y  output  35  signed element of result C = H x D, row-major.
REQ-008 Y_valid  output  1  one-cycle pulse; Y holds a new C element.
REQ-009 busy  output  1  high from first accepted load beat until the last result is emitted.
REQ-010 done  output  1  one-cycle pulse coincident with the Y_valid of C[7][7].

Function
REQ-011 The block SHALL compute the 8x8 matrix product C[i][j] = sum over k=0..7 of H[i][k]*D[k][j], using 16x16 signed multiplies (32-bit products) accumulated at full 35-bit signed precision, with no truncation, rounding or saturation.
REQ-012 The FSM SHALL have states IDLE, LOAD and COMP.
REQ-013 IDLE/LOAD: on each rising edge with F=1, H SHALL be written to H-store[idx] and D to D-store[idx], with idx = 8*row+col counting 0..63; the first beat SHALL move IDLE->LOAD and assert busy.
REQ-014 F=0 during LOAD SHALL stall the load: no write, idx held, and no timeout.
REQ-015 The edge accepting beat 63 SHALL move the FSM to COMP with i=j=k=0.
REQ-016 COMP SHALL perform one multiply-accumulate per cycle, with k iterating fastest, then j, then i, for 512 cycles total.
REQ-017 At k=0 the accumulator SHALL load the product, discarding the previous sum.
REQ-018 At k=7 the accumulator SHALL register Y = accumulator + product and assert Y_valid for one cycle.
REQ-019 Latency: the Y_valid for element n (n = 8i+j) SHALL follow the edge 8*(n+1) clock edges after the edge that accepted beat 63, so there is exactly one Y_valid every 8 cycles.
REQ-020 Y SHALL hold its value between pulses.
REQ-021 On the edge producing C[7][7], done SHALL pulse, busy SHALL drop and the FSM SHALL return to IDLE.
REQ-022 A new load MAY start on the next edge.
REQ-023 F, H and D SHALL be ignored while in COMP; no error output SHALL exist.
REQ-024 Storage SHALL be two 64x16 register arrays or equivalent RAM with one read per matrix per cycle.
REQ-025 The stored matrices SHALL persist after done until they are overwritten by a new load.

Reset
REQ-026 While rst=1, asynchronously: the FSM SHALL be IDLE, idx/i/j/k SHALL be 0, the accumulator SHALL be 0, and Y, Y_valid, busy and done SHALL be 0.
REQ-027 Reset asserted mid-LOAD or mid-COMP SHALL abort the operation with no further Y_valid pulses; partially loaded matrix contents are don't-care and SHALL be fully overwritten by the next 64-beat load.
REQ-028 After rst is released, the first rising edge with F=1 SHALL be accepted as beat 0.

Verification
REQ-029 H = identity, D[n] = n (0..63), F held high for 64 cycles -> 64 Y_valid pulses with Y = 0,1,...,63 in order, spaced 8 cycles, and done on the last pulse.
REQ-030 H = D = all +1 -> every Y = 8; H = D = all -32768 -> every Y = 8589934592 (2^33), with no overflow.
REQ-031 Mixed signs, H = all 32767 and D = all -32768 -> every Y = -8589672448.
REQ-032 F toggled 1,0,1,0 during load (128 cycles for 64 beats) -> results identical to the gap-free load; the first Y_valid occurs 8 edges after the final beat.
REQ-033 rst pulsed after the 10th Y_valid -> all outputs 0 immediately, no further pulses; a fresh load then produces a correct full 64-element sequence.
REQ-034 F held high and H/D toggling throughout COMP -> results unaffected, and busy=1 continuously until done.

Source files
------------

// File: rtl/multiplier_8x8.sv
// 8x8 matrix multiplier: streams in H and D row-major, then emits C = H x D
// one element every 8 cycles using a single 16x16 signed MAC.
//
// state | meaning
// IDLE  | waiting for the first load beat
// LOAD  | accepting H/D beats 0..63 (F=0 stalls)
// COMP  | one multiply-accumulate per cycle, k fastest, then j, then i
module multiplier_8x8 (
    input  logic               clk,
    input  logic               rst,
    input  logic               F,
    input  logic signed [15:0] H,
    input  logic signed [15:0] D,
    output logic signed [34:0] Y,
    output logic               Y_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, LOAD, COMP} state_t;

    state_t state, state_next;

    logic        [5:0]  idx;
    logic        [2:0]  i_cnt, j_cnt, k_cnt;
    logic signed [15:0] h_store [64];
    logic signed [15:0] d_store [64];
    logic signed [15:0] h_rd, d_rd;
    logic signed [31:0] product;
    logic signed [34:0] product_ext;
    logic signed [34:0] acc;
    logic               load_beat, last_beat, last_mac;

    assign load_beat = F && (state != COMP);
    assign last_beat = load_beat && (idx == 6'd63);
    assign last_mac  = (state == COMP) && (i_cnt == 3'd7) && (j_cnt == 3'd7) && (k_cnt == 3'd7);

    assign h_rd        = h_store[{i_cnt, k_cnt}];
    assign d_rd        = d_store[{k_cnt, j_cnt}];
    assign product     = $signed({{16{h_rd[15]}}, h_rd}) * $signed({{16{d_rd[15]}}, d_rd});
    assign product_ext = $signed({{3{product[31]}}, product});

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load_beat) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (last_beat) begin
                    state_next = COMP;
                end
            end
            COMP: begin
                if (last_mac) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Matrix storage needs no reset: every load overwrites all 64 entries.
    always_ff @(posedge clk) begin
        if (load_beat) begin
            h_store[idx] <= H;
            d_store[idx] <= D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            k_cnt   <= '0;
            acc     <= '0;
            Y       <= '0;
            Y_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            Y_valid <= 1'b0;
            done    <= 1'b0;
            if (load_beat) begin
                idx <= idx + 6'd1;
            end
            if (last_beat) begin
                i_cnt <= '0;
                j_cnt <= '0;
                k_cnt <= '0;
            end else if (state == COMP) begin
                k_cnt <= k_cnt + 3'd1;
                if (k_cnt == 3'd0) begin
                    acc <= product_ext;
                end else begin
                    acc <= acc + product_ext;
                end
                // Final term bypasses the accumulator straight into Y.
                if (k_cnt == 3'd7) begin
                    j_cnt   <= j_cnt + 3'd1;
                    Y       <= acc + product_ext;
                    Y_valid <= 1'b1;
                    done    <= last_mac;
                    if (j_cnt == 3'd7) begin
                        i_cnt <= i_cnt + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multiplier_8x8.sv
// Bench for multiplier_8x8: directed and random matrices against a plain
// arithmetic matrix-product model, including stalls, COMP noise and resets.
module tb_multiplier_8x8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               F   = 1'b0;
    logic signed [15:0] H   = '0;
    logic signed [15:0] D   = '0;
    logic signed [34:0] Y;
    logic               Y_valid;
    logic               busy;
    logic               done;

    int     vectors     = 0;
    int     miscompares = 0;
    int     h_m [64];
    int     d_m [64];
    longint c_m [64];
    longint y_hold      = 0;

    multiplier_8x8 dut (
        .clk     (clk),
        .rst     (rst),
        .F       (F),
        .H       (H),
        .D       (D),
        .Y       (Y),
        .Y_valid (Y_valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model();
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                longint s = 0;
                for (int k = 0; k < 8; k++) begin
                    s += longint'(h_m[8*i+k]) * longint'(d_m[8*k+j]);
                end
                c_m[8*i+j] = s;
            end
        end
    endtask

    task automatic fill_const(input int hv, input int dv);
        for (int b = 0; b < 64; b++) begin
            h_m[b] = hv;
            d_m[b] = dv;
        end
    endtask

    task automatic fill_rand();
        for (int b = 0; b < 64; b++) begin
            h_m[b] = int'($urandom_range(65535)) - 32768;
            d_m[b] = int'($urandom_range(65535)) - 32768;
        end
        h_m[$urandom_range(63)] = -32768;
        d_m[$urandom_range(63)] = -32768;
    endtask

    task automatic load(input bit gap, input int beats);
        for (int b = 0; b < beats; b++) begin
            F = 1'b1;
            H = 16'(h_m[b]);
            D = 16'(d_m[b]);
            @(posedge clk);
            #1;
            chk("busy_load", busy, 1);
            if (gap && b < beats - 1) begin
                F = 1'b0;
                H = 16'($urandom);
                D = 16'($urandom);
                @(posedge clk);
                #1;
                chk("busy_stall", busy, 1);
                chk("valid_stall", Y_valid, 0);
            end
        end
        F = 1'b0;
    endtask

    task automatic do_reset();
        F = 1'b0;
        rst = 1'b1;
        #1;
        y_hold = 0;
        chk("rst_y", Y, 0);
        chk("rst_valid", Y_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", Y_valid, 0);
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("post_rst_valid", Y_valid, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_y", Y, 0);
        end
    endtask

    // Checks every edge after the final load beat; optionally drives COMP
    // noise, or resets right after result number rst_after.
    task automatic run_comp(input bit noise, input int rst_after);
        int n = 0;
        model();
        for (int e = 1; e <= 512; e++) begin
            bit vexp;
            if (noise) begin
                F = 1'b1;
                H = 16'($urandom);
                D = 16'($urandom);
            end else begin
                F = 1'b0;
            end
            @(posedge clk);
            #1;
            vexp = (e % 8 == 0);
            chk("y_valid", Y_valid, vexp);
            if (vexp) begin
                y_hold = c_m[n];
                n++;
            end
            chk("y", Y, y_hold);
            chk("done", done, e == 512);
            chk("busy", busy, e != 512);
            if (rst_after != 0 && n == rst_after) begin
                do_reset();
                return;
            end
        end
        F = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("init_y", Y, 0);
        chk("init_valid", Y_valid, 0);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);

        for (int b = 0; b < 64; b++) begin
            h_m[b] = (b / 8 == b % 8) ? 1 : 0;
            d_m[b] = b;
        end
        load(1'b0, 64);
        run_comp(1'b0, 0);

        fill_const(1, 1);
        load(1'b0, 64);
        run_comp(1'b0, 0);

        fill_const(-32768, -32768);
        load(1'b0, 64);
        run_comp(1'b0, 0);

        fill_const(32767, -32768);
        load(1'b0, 64);
        run_comp(1'b0, 0);

        fill_rand();
        load(1'b1, 64);
        run_comp(1'b0, 0);

        fill_rand();
        load(1'b0, 64);
        run_comp(1'b1, 0);

        fill_rand();
        load(1'b0, 64);
        run_comp(1'b0, 10);
        fill_rand();
        load(1'b0, 64);
        run_comp(1'b0, 0);

        fill_rand();
        load(1'b0, 20);
        do_reset();
        fill_rand();
        load(1'b1, 64);
        run_comp(1'b0, 0);

        repeat (4) begin
            @(posedge clk);
            #1;
            chk("tail_valid", Y_valid, 0);
            chk("tail_busy", busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
